// File: rtl/pipe_commit_monitor.sv
// Single-token pipeline tracker: follows one issued token through NUM_STAGES stall-controlled
// stages and reports start, commit, latency, timeout, squash and stall-contract violations.
module pipe_commit_monitor #(
  parameter int unsigned NUM_STAGES = 4,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned MAX_CYCLES = 50
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_i,
  input  logic [NUM_STAGES-1:0] stall_i,
  input  logic [NUM_STAGES-1:0] flush_i,
  output logic                  start_o,
  output logic                  started_o,
  output logic [NUM_STAGES-1:0] stage_occ_o,
  output logic                  commit_o,
  output logic                  ended_o,
  output logic                  timeout_o,
  output logic                  squashed_o,
  output logic                  protocol_err_o,
  output logic [CNT_W-1:0]      cycle_cnt_o,
  output logic [CNT_W-1:0]      latency_o
);

  localparam int unsigned      LAST     = NUM_STAGES - 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] DEADLINE = CNT_W'(MAX_CYCLES);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    FLIGHT = 3'd2,
    DONE   = 3'd3,
    LATE   = 3'd4,
    SQUASH = 3'd5
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [NUM_STAGES-1:0] occ_d;
  logic [NUM_STAGES-1:0] adv;
  logic [NUM_STAGES-1:0] kill;
  logic                  issue_fire;
  logic                  commit_d;
  logic                  squash_now;
  logic                  stall_viol;
  logic                  any_end;
  logic                  set_ended;
  logic                  set_timeout;
  logic                  set_squash;
  logic                  cnt_run;

  // Token movement: flush beats stall, stall beats advance
  always_comb begin
    kill     = stage_occ_o & flush_i;
    adv      = stage_occ_o & ~stall_i & ~flush_i;
    occ_d    = '0;
    occ_d[0] = stage_occ_o[0] & stall_i[0] & ~flush_i[0];
    for (int unsigned k = 1; k < NUM_STAGES; k++) begin
      occ_d[k] = adv[k-1] | (stage_occ_o[k] & stall_i[k] & ~flush_i[k]);
    end
  end

  // A token moving into a stage that is stalled this cycle breaks the stall contract
  assign stall_viol = |(adv[LAST-1:0] & stall_i[LAST:1]);
  assign commit_d   = adv[LAST];
  assign squash_now = (|kill) & ~(|occ_d);
  assign issue_fire = (state_q == IDLE) & issue_i;
  assign any_end    = ended_o | timeout_o | squashed_o;

  // Next-state and terminal-event decode
  always_comb begin
    state_d     = state_q;
    set_ended   = 1'b0;
    set_timeout = 1'b0;
    set_squash  = 1'b0;
    case (state_q)
      IDLE: begin
        if (issue_i) state_d = LAUNCH;
      end
      LAUNCH: begin
        if (squash_now) begin
          set_squash = 1'b1;
          state_d    = SQUASH;
        end else begin
          state_d = FLIGHT;
        end
      end
      FLIGHT: begin
        if (commit_o) begin
          set_ended = 1'b1;
          state_d   = DONE;
        end else if (squash_now) begin
          set_squash = 1'b1;
          state_d    = SQUASH;
        end else if ((cycle_cnt_o == DEADLINE) && !commit_d) begin
          set_timeout = 1'b1;
          state_d     = LATE;
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  // Counter runs from launch until any terminal flag is about to be set
  assign cnt_run = (start_o | started_o) & ~any_end & ~set_ended & ~set_timeout & ~set_squash;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_o        <= 1'b0;
      started_o      <= 1'b0;
      stage_occ_o    <= '0;
      commit_o       <= 1'b0;
      ended_o        <= 1'b0;
      timeout_o      <= 1'b0;
      squashed_o     <= 1'b0;
      protocol_err_o <= 1'b0;
      cycle_cnt_o    <= '0;
      latency_o      <= '0;
    end else begin
      start_o   <= issue_fire;
      started_o <= started_o | start_o;
      commit_o  <= commit_d;

      stage_occ_o <= occ_d;
      if (issue_fire) stage_occ_o[0] <= 1'b1;

      if (set_ended)   ended_o    <= 1'b1;
      if (set_timeout) timeout_o  <= 1'b1;
      if (set_squash)  squashed_o <= 1'b1;
      if (stall_viol)  protocol_err_o <= 1'b1;

      if (commit_o) latency_o <= cycle_cnt_o;

      if (issue_fire) begin
        cycle_cnt_o <= '0;
      end else if (cnt_run && (cycle_cnt_o != CNT_MAX)) begin
        cycle_cnt_o <= cycle_cnt_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_commit_monitor.sv
// Bench for pipe_commit_monitor: directed scenarios plus random stall/flush episodes,
// every cycle compared against a token-position reference model.
module tb_pipe_commit_monitor;

  localparam int unsigned N    = 4;
  localparam int unsigned CW   = 8;
  localparam int unsigned MAXC = 50;

  logic          clk;
  logic          rst_n;
  logic          issue;
  logic [N-1:0]  stall;
  logic [N-1:0]  flush;
  logic          start_o;
  logic          started_o;
  logic [N-1:0]  stage_occ_o;
  logic          commit_o;
  logic          ended_o;
  logic          timeout_o;
  logic          squashed_o;
  logic          protocol_err_o;
  logic [CW-1:0] cycle_cnt_o;
  logic [CW-1:0] latency_o;

  int    n_asserts = 0;
  int    n_fail    = 0;
  string ep        = "init";

  // Reference model state: token position (-1 = nowhere) and sticky event record
  int m_pos;
  bit m_issued, m_start, m_started, m_commit;
  bit m_ended, m_timeout, m_squashed, m_perr;
  int m_cnt, m_lat;

  pipe_commit_monitor #(.NUM_STAGES(N), .CNT_W(CW), .MAX_CYCLES(MAXC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .issue_i        (issue),
    .stall_i        (stall),
    .flush_i        (flush),
    .start_o        (start_o),
    .started_o      (started_o),
    .stage_occ_o    (stage_occ_o),
    .commit_o       (commit_o),
    .ended_o        (ended_o),
    .timeout_o      (timeout_o),
    .squashed_o     (squashed_o),
    .protocol_err_o (protocol_err_o),
    .cycle_cnt_o    (cycle_cnt_o),
    .latency_o      (latency_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s/%s: observed=%0h expected=%0h", ep, tag, obs, exp);
      end
  endtask

  task automatic model_reset();
    m_pos = -1;
    m_issued = 0; m_start = 0; m_started = 0; m_commit = 0;
    m_ended = 0; m_timeout = 0; m_squashed = 0; m_perr = 0;
    m_cnt = 0; m_lat = 0;
  endtask

  // One clock of the spec rules, applied to the inputs present during that cycle
  task automatic model_step(input bit iss, input logic [N-1:0] st, input logic [N-1:0] fl);
    int n_pos;
    bit n_start, n_commit, ev_end, ev_to, ev_sq, flags;
    n_pos = m_pos; n_start = 0; n_commit = 0; ev_end = 0; ev_to = 0; ev_sq = 0;
    flags = m_ended || m_timeout || m_squashed;
    if (m_pos >= 0) begin
      if (fl[m_pos]) begin
        n_pos = -1;
        ev_sq = !flags;
      end else if (!st[m_pos]) begin
        if (m_pos == int'(N) - 1) begin
          n_pos = -1;
          n_commit = 1;
        end else begin
          n_pos = m_pos + 1;
          if (st[m_pos + 1]) m_perr = 1;
        end
      end
    end
    if (m_commit && !flags) ev_end = 1;
    if (m_started && !flags && !m_commit && !ev_sq && !n_commit && m_cnt == int'(MAXC)) ev_to = 1;
    if (m_commit) m_lat = m_cnt;
    if (!m_issued && iss) begin
      m_issued = 1;
      n_start = 1;
      n_pos = 0;
      m_cnt = 0;
    end else if ((m_start || m_started) && !flags && !ev_end && !ev_to && !ev_sq) begin
      if (m_cnt < (1 << CW) - 1) m_cnt++;
    end
    if (m_start) m_started = 1;
    if (ev_end) m_ended = 1;
    if (ev_to) m_timeout = 1;
    if (ev_sq) m_squashed = 1;
    m_start = n_start;
    m_commit = n_commit;
    m_pos = n_pos;
  endtask

  task automatic check_all();
    logic [N-1:0] exp_occ;
    exp_occ = '0;
    if (m_pos >= 0) exp_occ[m_pos] = 1'b1;
    chk("start",     32'(start_o),        32'(m_start));
    chk("started",   32'(started_o),      32'(m_started));
    chk("occ",       32'(stage_occ_o),    32'(exp_occ));
    chk("commit",    32'(commit_o),       32'(m_commit));
    chk("ended",     32'(ended_o),        32'(m_ended));
    chk("timeout",   32'(timeout_o),      32'(m_timeout));
    chk("squashed",  32'(squashed_o),     32'(m_squashed));
    chk("proto_err", 32'(protocol_err_o), 32'(m_perr));
    chk("cycle_cnt", 32'(cycle_cnt_o),    32'(m_cnt));
    chk("latency",   32'(latency_o),      32'(m_lat));
  endtask

  task automatic cycle(input bit iss, input logic [N-1:0] st, input logic [N-1:0] fl);
    issue = iss; stall = st; flush = fl;
    @(posedge clk);
    model_step(iss, st, fl);
    @(negedge clk);
    check_all();
  endtask

  task automatic check_zero();
    chk("rst_start",   32'(start_o),        32'd0);
    chk("rst_started", 32'(started_o),      32'd0);
    chk("rst_occ",     32'(stage_occ_o),    32'd0);
    chk("rst_commit",  32'(commit_o),       32'd0);
    chk("rst_flags",   32'({ended_o, timeout_o, squashed_o, protocol_err_o}), 32'd0);
    chk("rst_cnt",     32'(cycle_cnt_o),    32'd0);
    chk("rst_lat",     32'(latency_o),      32'd0);
  endtask

  task automatic do_reset();
    issue = 1'b0; stall = '0; flush = '0;
    rst_n = 1'b0;
    #1;
    check_zero();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_all();
  endtask

  initial begin
    rst_n = 1'b0; issue = 1'b0; stall = '0; flush = '0;
    model_reset();
    @(negedge clk);

    // Unstalled flight: latency equals depth
    ep = "basic";
    do_reset();
    cycle(1, '0, '0);
    chk("c1_start", 32'(start_o), 32'd1);
    chk("c1_occ", 32'(stage_occ_o), 32'b0001);
    repeat (3) cycle(0, '0, '0);
    chk("c4_occ", 32'(stage_occ_o), 32'b1000);
    cycle(0, '0, '0);
    chk("c5_commit", 32'(commit_o), 32'd1);
    cycle(0, '0, '0);
    chk("c6_lat", 32'(latency_o), 32'd4);
    chk("c6_ended", 32'(ended_o), 32'd1);
    repeat (3) cycle(1, '0, '0);

    // Legal stall of S2 for three cycles
    ep = "stall_s2";
    do_reset();
    cycle(1, '0, '0);
    cycle(0, '0, '0);
    repeat (3) cycle(0, 4'b0010, '0);
    repeat (4) cycle(0, '0, '0);
    chk("lat7", 32'(latency_o), 32'd7);
    chk("no_perr", 32'(protocol_err_o), 32'd0);

    // Permanent stall runs into the deadline
    ep = "timeout";
    do_reset();
    cycle(1, 4'b1111, '0);
    repeat (60) cycle(0, 4'b1111, '0);
    chk("to_flag", 32'(timeout_o), 32'd1);
    chk("to_cnt", 32'(cycle_cnt_o), 32'(MAXC));
    chk("to_ended", 32'(ended_o), 32'd0);

    // Flush the token in S3
    ep = "squash";
    do_reset();
    cycle(1, '0, '0);
    repeat (2) cycle(0, '0, '0);
    cycle(0, '0, 4'b0100);
    chk("sq_flag", 32'(squashed_o), 32'd1);
    chk("sq_occ", 32'(stage_occ_o), 32'd0);
    repeat (8) cycle(0, '0, '0);

    // Token moves into a stalled S2
    ep = "proto";
    do_reset();
    cycle(1, '0, '0);
    cycle(0, 4'b0010, '0);
    chk("pe_flag", 32'(protocol_err_o), 32'd1);
    chk("pe_occ", 32'(stage_occ_o), 32'b0010);
    repeat (6) cycle(0, '0, '0);

    // Asynchronous reset mid-flight, then relaunch
    ep = "async_rst";
    do_reset();
    cycle(1, '0, '0);
    repeat (2) cycle(0, '0, '0);
    chk("ar_occ", 32'(stage_occ_o), 32'b0100);
    #2;
    do_reset();
    cycle(1, '0, '0);
    chk("ar_restart", 32'(start_o), 32'd1);
    repeat (6) cycle(0, '0, '0);

    // Random stall/flush episodes
    for (int e = 0; e < 14; e++) begin
      int           sp;
      logic [N-1:0] st;
      logic [N-1:0] fl;
      bit           iss;
      ep = $sformatf("rand%0d", e);
      sp = (e % 3 == 0) ? 70 : 20;
      do_reset();
      for (int c = 0; c < 75; c++) begin
        iss = ($urandom_range(3, 0) == 0);
        for (int b = 0; b < int'(N); b++) begin
          st[b] = ($urandom_range(99, 0) < sp);
          fl[b] = ($urandom_range(99, 0) < 2);
        end
        cycle(iss, st, fl);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
